// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states,
// reset address default, instruction field positions and target helpers.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [31:0] instr);
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [31:0] offset);
        return pc4 + {offset[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction buffer between fetch and decode: power-of-two depth,
// wrapping pointers, occupancy counter, synchronous flush.
module instr_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the buffer outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage; a push coinciding with a flush is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding an
// instruction buffer, with branch/jump redirect and stale-response discard.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic [31:0] PCPlus4,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic [31:0] BranchOffset
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_e state, state_nxt;
    logic [31:0]  fetch_pc, fetch_pc_nxt;
    logic [31:0]  req_pc;
    logic         running;

    fetch_entry_t buf_head;
    fetch_entry_t buf_in;
    logic         buf_full, buf_empty;
    logic         buf_push;

    logic         fetch_req;
    logic         grant;
    logic         issue;
    logic         redirect;
    logic [31:0]  head_pc4;
    logic [31:0]  redirect_pc;

    assign fetch_req   = running & (state == FETCH) & ~buf_full;
    assign grant       = fetch_req & IMemGnt;
    assign issue       = InstrValid & InstrReady;
    assign redirect    = issue & (PCSrc | Jump);
    assign head_pc4    = buf_head.pc + 32'd4;
    assign redirect_pc = Jump ? jump_target(head_pc4, buf_head.instr)
                              : branch_target(head_pc4, BranchOffset);

    assign IMemReq    = fetch_req;
    assign IMemAddr   = {fetch_pc[31:2], 2'b00};
    assign InstrValid = ~buf_empty;
    assign Instr      = buf_empty ? '0 : buf_head.instr;
    assign PCPlus4    = buf_empty ? '0 : head_pc4;
    assign Op         = Instr[OP_MSB:OP_LSB];
    assign Funct      = Instr[FUNCT_MSB:FUNCT_LSB];
    assign buf_in     = '{pc: req_pc, instr: IMemRData};

    // Requests start only on the first edge after reset release, so a
    // response still in flight from before reset lands in an idle FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) running <= 1'b0;
        else        running <= 1'b1;
    end

    // FSM state, fetch address and address of the outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC_ALIGNED;
            req_pc   <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (grant) req_pc <= IMemAddr;
        end
    end

    // Next-state, next fetch address and buffer push decision.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        buf_push     = 1'b0;
        case (state)
            FETCH: begin
                if (grant) begin
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    state_nxt    = WAIT;
                end
                if (redirect) begin
                    fetch_pc_nxt = redirect_pc;
                    if (grant) state_nxt = DISCARD;
                end
            end
            WAIT: begin
                if (IMemRValid) begin
                    buf_push  = ~redirect;
                    state_nxt = FETCH;
                end
                // A response arriving with the redirect is already the stale
                // one, so there is nothing left to discard.
                if (redirect) begin
                    fetch_pc_nxt = redirect_pc;
                    if (!IMemRValid) state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (IMemRValid) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    instr_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_instr_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (buf_push),
        .push_entry (buf_in),
        .pop        (issue),
        .flush      (redirect),
        .head       (buf_head),
        .full       (buf_full),
        .empty      (buf_empty)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a memory model with random grant and
// latency, and a program-order model of which instruction must issue next
// and which address must be requested next.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRValid;
    logic [31:0] IMemRData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic [31:0] PCPlus4;
    logic        PCSrc;
    logic        Jump;
    logic [31:0] BranchOffset;

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemGnt      (IMemGnt),
        .IMemRValid   (IMemRValid),
        .IMemRData    (IMemRData),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Instr        (Instr),
        .Op           (Op),
        .Funct        (Funct),
        .PCPlus4      (PCPlus4),
        .PCSrc        (PCSrc),
        .Jump         (Jump),
        .BranchOffset (BranchOffset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests;
    int unsigned n_fail;

    // stimulus knobs
    int unsigned p_gnt, p_ready, p_redir, lat_min, lat_max;
    bit          dir_mode, done_br, done_j;

    // reference model
    logic [31:0] exp_pc;
    logic [31:0] exp_gnt_addr;
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          cyc;
    int          n_gnt, n_iss, first_gnt, first_valid;
    logic [31:0] last_gnt_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0800_0040;
        return {a[15:0] ^ 16'hC3A5, a[17:2]};
    endfunction

    task automatic do_reset();
        rst_n        = 1'b0;
        IMemGnt      = 1'b0;
        IMemRValid   = 1'b0;
        IMemRData    = '0;
        InstrReady   = 1'b0;
        PCSrc        = 1'b0;
        Jump         = 1'b0;
        BranchOffset = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_req",   32'(IMemReq),    32'd0);
        check_eq("rst_valid", 32'(InstrValid), 32'd0);
        check_eq("rst_instr", Instr,           32'd0);
        check_eq("rst_pc4",   PCPlus4,         32'd0);
        q_addr.delete();
        q_due.delete();
        exp_pc       = RST_PC;
        exp_gnt_addr = RST_PC;
        n_gnt = 0; n_iss = 0; first_gnt = -1; first_valid = -1;
        done_br = 1'b0; done_j = 1'b0;
        // a leftover response shows up right as reset releases
        IMemRValid = 1'b1;
        IMemRData  = 32'hDEAD_BEEF;
        rst_n      = 1'b1;
        #1;
        check_eq("rel_req_low", 32'(IMemReq), 32'd0);
        @(negedge clk);
        check_eq("req_first_edge", 32'(IMemReq), 32'd1);
        check_eq("stale_ignored", 32'(InstrValid), 32'd0);
        IMemRValid = 1'b0;
    endtask

    task automatic step();
        logic        gnt, rdy, issue, redir, jmp, br, rv;
        logic [31:0] off, tgt, e, pc4;
        int          q_before;
        @(negedge clk);
        q_before = q_addr.size();
        if (IMemReq) check_eq("req_addr", IMemAddr, exp_gnt_addr);
        if (InstrValid) begin
            e = memfn(exp_pc);
            check_eq("head_pc4",   PCPlus4,     exp_pc + 32'd4);
            check_eq("head_instr", Instr,       e);
            check_eq("head_op",    32'(Op),     32'(e[31:26]));
            check_eq("head_funct", 32'(Funct),  32'(e[5:0]));
            if (first_valid < 0) first_valid = cyc;
        end
        rv = (q_before != 0) && (q_due[0] <= cyc);
        IMemRValid = rv;
        IMemRData  = rv ? memfn(q_addr[0]) : $urandom;
        if (rv) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        gnt   = ($urandom_range(99) < p_gnt);
        rdy   = ($urandom_range(99) < p_ready);
        issue = InstrValid && rdy;
        jmp   = 1'($urandom);
        br    = 1'($urandom);
        off   = $urandom;
        tgt   = exp_pc;
        if (issue) begin
            n_iss++;
            jmp = 1'b0;
            br  = 1'b0;
            if (dir_mode && exp_pc == 32'h10 && !done_br) begin
                br = 1'b1; off = 32'hFFFF_FFFE; done_br = 1'b1;
            end else if (dir_mode && exp_pc == 32'h100 && !done_j) begin
                br = 1'b1; jmp = 1'b1; done_j = 1'b1;
            end else if ($urandom_range(99) < p_redir) begin
                jmp = 1'($urandom);
                br  = 1'($urandom);
                if (!jmp) br = 1'b1;
                off = 32'($urandom_range(64)) - 32'd32;
            end
            pc4 = exp_pc + 32'd4;
            e   = memfn(exp_pc);
            if (jmp)     tgt = {pc4[31:28], e[25:0], 2'b00};
            else if (br) tgt = pc4 + (off << 2);
            else         tgt = pc4;
            exp_pc = tgt;
        end
        redir        = issue && (jmp || br);
        IMemGnt      = gnt;
        InstrReady   = rdy;
        PCSrc        = br;
        Jump         = jmp;
        BranchOffset = off;
        if (IMemReq && gnt) begin
            check_eq("one_outstanding", 32'(q_before), 32'd0);
            q_addr.push_back(IMemAddr);
            q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            last_gnt_addr = IMemAddr;
            n_gnt++;
            if (first_gnt < 0) first_gnt = cyc;
            exp_gnt_addr = exp_gnt_addr + 32'd4;
        end
        if (redir) exp_gnt_addr = tgt;
        cyc++;
    endtask

    initial begin
        int g0;
        n_tests = 0; n_fail = 0; cyc = 0;
        last_gnt_addr = '0;
        dir_mode = 1'b0;

        // in-order fetch, single-cycle memory, decode always ready
        p_gnt = 100; p_ready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 30 && n_iss < 3; i++) step();
        check_eq("a_progress",  32'(n_iss >= 3), 32'd1);
        check_eq("a_first_lat", 32'(first_gnt >= 0 && first_valid - first_gnt >= 2), 32'd1);

        // decode stalled: buffer fills after two pushes, then resumes at 8
        do_reset();
        p_ready = 0;
        for (int i = 0; i < 10; i++) step();
        check_eq("full_noreq",  32'(IMemReq),    32'd0);
        check_eq("full_valid",  32'(InstrValid), 32'd1);
        check_eq("full_pushes", 32'(n_gnt),      32'd2);
        p_ready = 100;
        g0 = n_gnt;
        for (int i = 0; i < 20 && n_gnt == g0; i++) step();
        check_eq("resume_addr", last_gnt_addr, 32'h8);

        // directed branch at 0x10 (offset -2) and jump-over-branch at 0x100
        do_reset();
        dir_mode = 1'b1;
        for (int i = 0; i < 600 && !(done_j && exp_pc == 32'h108); i++) step();
        check_eq("dir_progress", 32'(done_j && done_br && exp_pc == 32'h108), 32'd1);
        dir_mode = 1'b0;

        // redirects against a 3-cycle memory
        do_reset();
        p_redir = 50; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 200; i++) step();

        // asynchronous reset with a request outstanding
        p_redir = 0;
        for (int i = 0; i < 10 && q_addr.size() == 0; i++) step();
        check_eq("e_outstanding", 32'(q_addr.size()), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_req",   32'(IMemReq),    32'd0);
        check_eq("async_valid", 32'(InstrValid), 32'd0);
        check_eq("async_instr", Instr,           32'd0);
        check_eq("async_pc4",   PCPlus4,         32'd0);
        do_reset();
        for (int i = 0; i < 100; i++) step();

        // fully random traffic
        p_gnt = 60; p_ready = 60; p_redir = 25; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 2000; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
